dmem_responder: RTL and testbench

Data-memory responder for the core's `d_mem_*` bus: it is the target end of the LSU's request interface. It accepts one 16-bit word read or write per request, with byte-lane enables and a programmable number of wait states. It serves from an internal word-addressed array, so it works as the bench and FPGA data RAM behind `core`. Wait states are produced by holding `d_mem_rdy` low, which stalls the core exactly as a slow external memory would.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 90 +++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory bus between the LSU (initiator) and a memory target.
interface dmem_responder_if;
  logic        d_mem_assert;
  logic        d_mem_cmd;
  logic [15:0] d_mem_addr;
  logic [15:0] d_mem_data_out;
  logic        d_mem_be0;
  logic        d_mem_be1;
  logic        d_mem_rdy;
  logic [15:0] d_mem_data_in;

  modport master (
    output d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_data_out, d_mem_be0, d_mem_be1,
    input  d_mem_rdy, d_mem_data_in
  );

  modport slave (
    input  d_mem_assert, d_mem_cmd, d_mem_addr, d_mem_data_out, d_mem_be0, d_mem_be1,
    output d_mem_rdy, d_mem_data_in
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM answering the core's d_mem bus, with byte lanes
// and a fixed number of wait states inserted by holding rdy low.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             a_rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  typedef struct packed {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } req_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  req_t        req;
  logic [15:0] rdata;
  logic        latch, dec, access;

  logic [15:0] mem [2**ADDR_W];

  // Byte-address bit 0 and the bits above the word index never select anything.
  logic addr_unused;
  assign addr_unused = ^{bus.d_mem_addr[0], bus.d_mem_addr[15:ADDR_W+1]};

  // Next state and per-cycle controls; a dropped assert while waiting aborts.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    dec       = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: if (bus.d_mem_assert) begin
        latch     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (!bus.d_mem_assert)  state_nxt = IDLE;
        else if (cnt != 4'd0)   dec = 1'b1;
        else begin
          access    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter, latched request and read-data register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      req   <= '0;
      rdata <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (latch)    cnt <= WAIT_LD;
      else if (dec) cnt <= cnt - 4'd1;
      if (latch)
        req <= '{cmd:  bus.d_mem_cmd,
                 addr: bus.d_mem_addr[ADDR_W:1],
                 data: bus.d_mem_data_out,
                 be:   {bus.d_mem_be1, bus.d_mem_be0}};
      if (access && !req.cmd) rdata <= mem[req.addr];
    end
  end

  // Array write on the edge entering ACK; only enabled byte lanes change.
  always_ff @(posedge clk) begin
    if (access && req.cmd) begin
      if (req.be[0]) mem[req.addr][7:0]  <= req.data[7:0];
      if (req.be[1]) mem[req.addr][15:8] <= req.data[15:8];
    end
  end

  assign bus.d_mem_rdy     = (state == ACK);
  assign bus.d_mem_data_in = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 1 wait states) share one
// stimulus bus; a timestamp-based reference model checks both every cycle,
// and table/directed sequences check the wait-1 instance explicitly.
module tb_dmem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic a_rst = 1'b1;
  always #5 clk = ~clk;

  logic        as_i = 1'b0, cmd_i = 1'b0, be0_i = 1'b0, be1_i = 1'b0;
  logic [15:0] addr_i = '0, wdata_i = '0;

  dmem_responder_if bus0();
  dmem_responder_if bus1();

  assign bus0.d_mem_assert = as_i;    assign bus1.d_mem_assert = as_i;
  assign bus0.d_mem_cmd = cmd_i;      assign bus1.d_mem_cmd = cmd_i;
  assign bus0.d_mem_addr = addr_i;    assign bus1.d_mem_addr = addr_i;
  assign bus0.d_mem_data_out = wdata_i; assign bus1.d_mem_data_out = wdata_i;
  assign bus0.d_mem_be0 = be0_i;      assign bus1.d_mem_be0 = be0_i;
  assign bus0.d_mem_be1 = be1_i;      assign bus1.d_mem_be1 = be1_i;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (.clk(clk), .a_rst(a_rst), .bus(bus0.slave));
  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (.clk(clk), .a_rst(a_rst), .bus(bus1.slave));

  logic [1:0]  rdy_o;
  logic [15:0] dat_o [2];
  assign rdy_o[0] = bus0.d_mem_rdy;  assign dat_o[0] = bus0.d_mem_data_in;
  assign rdy_o[1] = bus1.d_mem_rdy;  assign dat_o[1] = bus1.d_mem_data_in;

  int vec = 0, bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  // ---------------- reference model (timestamps per request) ----------------
  int          cyc = 0;
  bit          pend [2] = '{0, 0};
  int          due  [2] = '{0, 0};
  int          blk  [2] = '{-10, -10};  // edge on which the ACK cycle ends
  bit          p_cmd [2];
  logic [15:0] p_addr [2], p_dat [2];
  bit   [1:0]  p_be [2];
  logic [15:0] mm [2][1024];
  bit   [1:0]  mk [2][1024];            // which bytes of each word are known
  bit          e_rdy [2] = '{0, 0};
  logic [15:0] e_dat [2] = '{16'h0, 16'h0};
  bit          e_dk  [2] = '{1, 1};

  task automatic model_edge(input int i);
    int wd;
    e_rdy[i] = 1'b0;
    if (pend[i]) begin
      if (!as_i) pend[i] = 1'b0;
      else if (cyc == due[i]) begin
        wd = int'(p_addr[i][AW:1]);
        if (p_cmd[i]) begin
          if (p_be[i][0]) begin mm[i][wd][7:0]  = p_dat[i][7:0];  mk[i][wd][0] = 1'b1; end
          if (p_be[i][1]) begin mm[i][wd][15:8] = p_dat[i][15:8]; mk[i][wd][1] = 1'b1; end
        end else begin
          e_dat[i] = mm[i][wd];
          e_dk[i]  = &mk[i][wd];
        end
        e_rdy[i] = 1'b1;
        pend[i]  = 1'b0;
        blk[i]   = cyc + 1;
      end
    end else if (as_i && cyc > blk[i]) begin
      pend[i]   = 1'b1;
      due[i]    = cyc + wc(i) + 1;
      p_cmd[i]  = cmd_i;
      p_addr[i] = addr_i;
      p_dat[i]  = wdata_i;
      p_be[i]   = {be1_i, be0_i};
    end
  endtask

  always @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int i = 0; i < 2; i++) begin
        pend[i] = 1'b0; blk[i] = -10; e_rdy[i] = 1'b0; e_dat[i] = 16'h0; e_dk[i] = 1'b1;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (a_rst) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d_rdy", i), {15'd0, rdy_o[i]}, {15'd0, e_rdy[i]});
        if (e_dk[i]) chk($sformatf("dut%0d_data", i), dat_o[i], e_dat[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input bit c, input logic [15:0] a, input logic [15:0] d,
                      input bit b0, input bit b1,
                      output logic [15:0] rd, output int lat);
    cmd_i = c; addr_i = a; wdata_i = d; be0_i = b0; be1_i = b1; as_i = 1'b1;
    lat = 0;
    rd  = 16'h0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rdy_o[1]) break;
      if (lat > 20) begin
        chk("xfer_timeout", 16'(lat), 16'(wc(1) + 2));
        break;
      end
    end
    rd   = dat_o[1];
    as_i = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    bit          cmd;
    logic [15:0] addr;
    logic [15:0] data;
    bit          b0, b1;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] pv(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {b, ~b};
  endfunction

  initial begin
    vec_t        tbl [12];
    logic [15:0] rd;
    int          lat, gap, npulse;
    logic [15:0] b2b_exp [3];

    tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 1'b1, 1'b1, 16'h0};
    tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
    tbl[2]  = '{1'b1, 16'h0006, 16'h1234, 1'b1, 1'b1, 16'h0};
    tbl[3]  = '{1'b1, 16'h0006, 16'hABCD, 1'b0, 1'b1, 16'h0};
    tbl[4]  = '{1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 16'hAB34};
    tbl[5]  = '{1'b1, 16'h0006, 16'h5566, 1'b1, 1'b0, 16'h0};
    tbl[6]  = '{1'b0, 16'h0007, 16'h0000, 1'b1, 1'b1, 16'hAB66};
    tbl[7]  = '{1'b1, 16'h0006, 16'hFFFF, 1'b0, 1'b0, 16'h0};
    tbl[8]  = '{1'b0, 16'h0006, 16'h0000, 1'b1, 1'b1, 16'hAB66};
    tbl[9]  = '{1'b1, 16'h0801, 16'hCAFE, 1'b1, 1'b1, 16'h0};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hCAFE};
    tbl[11] = '{1'b0, 16'hF810, 16'h0000, 1'b0, 1'b1, 16'hBEEF};

    // reset
    #3 a_rst = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    chk("reset_rdy", {15'd0, rdy_o[1]}, 16'h0);
    chk("reset_data", dat_o[1], 16'h0000);

    // preload words 0..15
    for (int w = 0; w < 16; w++) xfer(1'b1, 16'(w << 1), pv(w), 1'b1, 1'b1, rd, lat);

    // table: latency of every transfer, data of every read
    foreach (tbl[k]) begin
      xfer(tbl[k].cmd, tbl[k].addr, tbl[k].data, tbl[k].b0, tbl[k].b1, rd, lat);
      chk($sformatf("tbl%0d_latency", k), 16'(lat), 16'(wc(1) + 2));
      if (!tbl[k].cmd) chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp);
    end

    // back-to-back reads on the zero-wait instance
    xfer(1'b1, 16'h0000, 16'h1111, 1'b1, 1'b1, rd, lat);
    xfer(1'b1, 16'h0002, 16'h2222, 1'b1, 1'b1, rd, lat);
    xfer(1'b1, 16'h0004, 16'h3333, 1'b1, 1'b1, rd, lat);
    b2b_exp[0] = 16'h1111; b2b_exp[1] = 16'h2222; b2b_exp[2] = 16'h3333;
    cmd_i = 1'b0; addr_i = 16'h0000; as_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!rdy_o[0] && gap < 20);
      chk($sformatf("b2b%0d_rdy", k), {15'd0, rdy_o[0]}, 16'h1);
      chk($sformatf("b2b%0d_data", k), dat_o[0], b2b_exp[k]);
      if (k > 0) chk($sformatf("b2b%0d_gap", k), 16'(gap), 16'd3);
      addr_i = 16'((k + 1) << 1);
    end
    as_i = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a write to word 5
    xfer(1'b0, 16'h000A, 16'h0, 1'b1, 1'b1, rd, lat);
    chk("pre_reset_read", rd, pv(5));
    cmd_i = 1'b1; addr_i = 16'h000A; wdata_i = 16'h9999; be0_i = 1'b1; be1_i = 1'b1; as_i = 1'b1;
    @(posedge clk);
    #2 a_rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("async_rst%0d_rdy", i), {15'd0, rdy_o[i]}, 16'h0);
      chk($sformatf("async_rst%0d_data", i), dat_o[i], 16'h0000);
    end
    as_i = 1'b0;
    repeat (2) @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    xfer(1'b0, 16'h000A, 16'h0, 1'b1, 1'b1, rd, lat);
    chk("post_reset_word5", rd, pv(5));

    // abort: assert dropped in the second BUSY cycle of a write to word 2
    cmd_i = 1'b1; addr_i = 16'h0004; wdata_i = 16'hFFFF; be0_i = 1'b1; be1_i = 1'b1; as_i = 1'b1;
    npulse = 0;
    @(negedge clk); npulse += int'(rdy_o[1]);
    @(negedge clk); npulse += int'(rdy_o[1]);
    as_i = 1'b0;
    repeat (5) begin @(negedge clk); npulse += int'(rdy_o[1]); end
    chk("abort_no_rdy", 16'(npulse), 16'd0);
    xfer(1'b0, 16'h0004, 16'h0, 1'b1, 1'b1, rd, lat);
    chk("abort_word2", rd, 16'h3333);

    // randomized traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      as_i    = ($urandom_range(0, 9) < 7);
      cmd_i   = 1'($urandom);
      addr_i  = (16'($urandom) & 16'hF800) | 16'($urandom_range(0, 15) << 1) | 16'($urandom & 1);
      wdata_i = 16'($urandom);
      be0_i   = 1'($urandom);
      be1_i   = 1'($urandom);
      @(negedge clk);
    end
    as_i = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
